spi_flash_master: RTL and testbench
===================================

# spi_flash_master

Byte-wide SPI master, mode 0, MSB first, that replaces bit-banged access to the configuration flash (SCK/MOSI/MISO/CS). It sits downstream of the registered IO decode in the top level. It is fed by the delayed write/read strobes, the per-port select bits and the registered write data. It returns the received byte and status to the IO read mux.

## Interface
Parameters:
- DIV, default 4: SCK half-period in clk cycles; legal range 2..255.

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- wr_data  in  1  one-cycle strobe: write TX byte and start transfer (io_wr_ & data select)
- wr_ctrl  in  1  one-cycle strobe: write control register (io_wr_ & ctrl select)
- rd_data  in  1  one-cycle strobe: RX byte read by CPU (io_rd_ & data select)
- wdata  in  16  registered CPU write data; [7:0] used by wr_data; [0] = CS level and [1] = overrun clear for wr_ctrl
- rx_data  out  8  last received byte
- status  out  3  {overrun, done, busy}
- spi_sck  out  1  serial clock, idle low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in, asynchronous to clk
- spi_cs  out  1  chip select, active low, software controlled

## Operation
- States:
  - IDLE: waiting for a write.
  - LOW: SCK low for DIV cycles.
  - HIGH: SCK high for DIV cycles.
- Registers: 8-bit shift register, 3-bit bit counter, 8-bit half-period counter, one miso_q synchronizer flop, done, overrun, cs.
- IDLE + wr_data:
  - Load shift register with wdata[7:0], clear bit counter, enter LOW.
  - spi_mosi = wdata[7] from the next cycle.
- LOW: after DIV cycles, spi_sck rises and the block enters HIGH.
- HIGH:
  - On the last HIGH cycle, sample miso_q into the shift-register LSB.
  - Then spi_sck falls and the register shifts left; spi_mosi = new bit 7.
  - If 8 bits are done, go to IDLE: copy the shift register to rx_data and set done.
  - Otherwise return to LOW.
- busy = (state != IDLE).
- wr_data while busy: ignored (TX byte discarded, transfer unaffected); overrun set.
- wr_ctrl while idle: spi_cs <= wdata[0]; if wdata[1] = 1, clear overrun.
- wr_ctrl while busy: spi_cs is not changed; if wdata[1] = 1, overrun is still cleared.
- rd_data clears done. If completion and rd_data occur in the same cycle, done remains set (completion wins).
- wr_data and wr_ctrl never coincide (single IO write per cycle). If both are asserted, wr_data takes priority and the ctrl write is dropped.
- Reset values (asynchronous assertion):
  - state IDLE, spi_sck 0, spi_mosi 0, spi_cs 1, rx_data 0x00, done 0, overrun 0, busy 0.
- Reset mid-transfer: aborts immediately to the reset values; no partial rx_data update.

## Timing
- Cycle N: wr_data. Cycle N+1: busy = 1, spi_mosi valid, spi_sck = 0.
- spi_sck rises at N+1+DIV and at every 2·DIV thereafter.
- The transfer is exactly 8 SCK periods, so busy is high for exactly 16·DIV cycles (N+1 through N+16·DIV).
- rx_data and done update in the same cycle busy falls (N+16·DIV+1).
- spi_miso is registered once (miso_q). The sampled bit is the pin value DIV-1 or more cycles after the rising SCK edge, and before the falling edge.
- spi_mosi changes only in the cycle spi_sck falls (or at start), so it is stable for the whole SCK high phase.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back: a wr_data in the cycle busy falls is accepted; the next transfer starts with no idle gap required.
- spi_cs write takes effect the cycle after wr_ctrl.

## Test plan
- DIV=4, CS low, MISO looped to MOSI, write 0xA5 -> 8 SCK pulses, MOSI pattern 1,0,1,0,0,1,0,1; busy high exactly 64 cycles; rx_data = 0xA5; status = 3'b010.
- MISO tied high, write 0x00 -> MOSI low throughout, rx_data = 0xFF; a rd_data pulse afterwards -> done = 0.
- Write 0x3C, then write 0x81 at cycle 10 of the transfer -> transfer completes with 0x3C on MOSI, overrun = 1. Then wr_ctrl with wdata = 0x0002 -> overrun = 0 and spi_cs = 0.
- wr_ctrl wdata = 0x0001 during a transfer -> spi_cs unchanged until written again when idle. rd_data in the same cycle as completion -> done stays 1.
- Assert resetq low at cycle 20 of a transfer -> next sample: sck 0, mosi 0, cs 1, busy 0, rx_data unchanged from reset value 0x00. After release, a new transfer of 0x5A completes normally.
- DIV=2 with a slave model returning 0xC3 -> rx_data = 0xC3; busy high exactly 32 cycles.

Source files
------------

// File: rtl/spi_flash_master.sv
// Byte-wide SPI master (mode 0, MSB first) for the configuration flash.
// One write to the data port shifts a byte out on MOSI while the reply is shifted in from MISO.
module spi_flash_master #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        wr_data,
  input  logic        wr_ctrl,
  input  logic        rd_data,
  input  logic [15:0] wdata,
  output logic [7:0]  rx_data,
  output logic [2:0]  status,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs
);

  localparam logic [7:0] HALF_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  half_q, half_d;
  logic [7:0]  rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        miso_q;
  logic        busy;
  logic        half_end;
  logic        xfer_done;

  // Upper write-data byte only matters to other IO ports.
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:8];

  assign busy     = (state_q != IDLE);
  assign half_end = (half_q == HALF_LAST);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path leaves one unassigned (no latch).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    half_d    = half_q;
    rx_d      = rx_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    xfer_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_data) begin
          shift_d = wdata[7:0];
          bit_d   = 3'd0;
          half_d  = 8'd0;
          mosi_d  = wdata[7];
          state_d = LOW;
        end
      end
      LOW: begin
        if (half_end) begin
          half_d  = 8'd0;
          sck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      HIGH: begin
        if (half_end) begin
          // Sample and shift together as SCK falls; MOSI takes the new MSB.
          half_d  = 8'd0;
          sck_d   = 1'b0;
          shift_d = {shift_q[6:0], miso_q};
          mosi_d  = shift_q[6];
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_d      = {shift_q[6:0], miso_q};
            xfer_done = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = LOW;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Data write has priority; a ctrl write in the same cycle is dropped.
    if (wr_data) begin
      if (busy) ovr_d = 1'b1;
    end else if (wr_ctrl) begin
      if (wdata[1]) ovr_d = 1'b0;
      if (!busy)    cs_d  = wdata[0];
    end

    if (xfer_done)    done_d = 1'b1;
    else if (rd_data) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      half_q  <= 8'd0;
      rx_q    <= 8'h00;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      miso_q  <= spi_miso;
    end
  end

  assign rx_data  = rx_q;
  assign status   = {ovr_q, done_q, busy};
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench for spi_flash_master: one DUT at DIV=4 with MISO loopback/tie,
// one at DIV=2 talking to a small mode-0 slave that answers 0xC3.
module tb_spi_flash_master;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;

  logic        wr_data = 1'b0, wr_ctrl = 1'b0, rd_data = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [7:0]  rx_data;
  logic [2:0]  status;
  logic        sck, mosi, miso, cs;
  logic        loop_en = 1'b1;
  logic        miso_tie = 1'b0;

  logic        wr_data2 = 1'b0, wr_ctrl2 = 1'b0, rd_data2 = 1'b0;
  logic [15:0] wdata2 = 16'h0000;
  logic [7:0]  rx_data2;
  logic [2:0]  status2;
  logic        sck2, mosi2, miso2, cs2;
  logic [7:0]  slv = 8'hC3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_tie;

  // Mode-0 slave: first bit valid before the first rising edge, next bit after each falling edge.
  assign miso2 = slv[7];
  always @(negedge sck2) slv = {slv[6:0], 1'b0};

  spi_flash_master #(.DIV(4)) dut4 (
    .clk(clk), .resetq(resetq), .wr_data(wr_data), .wr_ctrl(wr_ctrl), .rd_data(rd_data),
    .wdata(wdata), .rx_data(rx_data), .status(status), .spi_sck(sck), .spi_mosi(mosi),
    .spi_miso(miso), .spi_cs(cs)
  );

  spi_flash_master #(.DIV(2)) dut2 (
    .clk(clk), .resetq(resetq), .wr_data(wr_data2), .wr_ctrl(wr_ctrl2), .rd_data(rd_data2),
    .wdata(wdata2), .rx_data(rx_data2), .status(status2), .spi_sck(sck2), .spi_mosi(mosi2),
    .spi_miso(miso2), .spi_cs(cs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ctrl(input logic [15:0] w);
    wdata = w; wr_ctrl = 1'b1;
    tick();
    wr_ctrl = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_data = 1'b1;
    tick();
    rd_data = 1'b0;
  endtask

  // Runs one DIV=4 transfer. At busy cycle k (1 = cycle after the write) an extra strobe is
  // applied: kind 1 = wr_data with kw, 2 = wr_ctrl with kw, 3 = rd_data.
  task automatic xfer4(input logic [7:0] tx, input int k, input int kind, input logic [15:0] kw,
                       output int cyc, output logic [7:0] mbits, output int pulses,
                       output logic mosi_or, output logic hi_glitch, output logic cs_or);
    logic prev_sck, prev_mosi;
    wdata = {8'h00, tx}; wr_data = 1'b1;
    tick();
    wr_data = 1'b0;
    cyc = 0; pulses = 0; mbits = 8'h00; mosi_or = 1'b0; hi_glitch = 1'b0; cs_or = 1'b0;
    prev_sck = 1'b0; prev_mosi = mosi;
    while (status[0] && cyc < 4000) begin
      cyc++;
      mosi_or = mosi_or | mosi;
      cs_or   = cs_or | cs;
      if (sck && !prev_sck) begin
        pulses++;
        mbits = {mbits[6:0], mosi};
      end
      if (sck && prev_sck && (mosi != prev_mosi)) hi_glitch = 1'b1;
      prev_sck = sck; prev_mosi = mosi;
      if (cyc == k) begin
        case (kind)
          1: begin wdata = kw; wr_data = 1'b1; end
          2: begin wdata = kw; wr_ctrl = 1'b1; end
          3: rd_data = 1'b1;
          default: ;
        endcase
      end
      tick();
      wr_data = 1'b0; wr_ctrl = 1'b0; rd_data = 1'b0;
    end
    if (cyc >= 4000) check("xfer4_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int          cyc, pulses;
    logic [7:0]  mbits;
    logic        mosi_or, glitch, cs_or;

    #12;
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_cs", 32'(cs), 32'd1);
    check("reset_rx", 32'(rx_data), 32'h00);
    check("reset_status", 32'(status), 32'd0);
    resetq = 1'b1;
    tick();

    pulse_ctrl(16'h0000);
    check("cs_low_after_ctrl", 32'(cs), 32'd0);

    // Loopback, 0xA5.
    loop_en = 1'b1;
    xfer4(8'hA5, 0, 0, 16'h0, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("a5_busy_cycles", 32'(cyc), 32'd64);
    check("a5_sck_pulses", 32'(pulses), 32'd8);
    check("a5_mosi_pattern", 32'(mbits), 32'hA5);
    check("a5_mosi_stable_high", 32'(glitch), 32'd0);
    check("a5_rx", 32'(rx_data), 32'hA5);
    check("a5_status", 32'(status), 32'b010);

    // MISO tied high, 0x00.
    loop_en = 1'b0; miso_tie = 1'b1;
    xfer4(8'h00, 0, 0, 16'h0, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("zero_mosi_low", 32'(mosi_or), 32'd0);
    check("zero_rx", 32'(rx_data), 32'hFF);
    check("zero_status", 32'(status), 32'b010);
    pulse_rd();
    check("rd_clears_done", 32'(status), 32'b000);

    // Overrun: second write at cycle 10 is discarded.
    loop_en = 1'b1;
    xfer4(8'h3C, 10, 1, 16'h0081, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("ovr_mosi_pattern", 32'(mbits), 32'h3C);
    check("ovr_busy_cycles", 32'(cyc), 32'd64);
    check("ovr_rx", 32'(rx_data), 32'h3C);
    check("ovr_status", 32'(status), 32'b110);
    pulse_ctrl(16'h0002);
    check("ovr_cleared_status", 32'(status), 32'b010);
    check("ovr_clear_cs", 32'(cs), 32'd0);

    // CS write during a transfer is ignored.
    xfer4(8'h96, 5, 2, 16'h0001, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("busy_ctrl_cs_held", 32'(cs_or), 32'd0);
    check("busy_ctrl_cs_after", 32'(cs), 32'd0);
    check("busy_ctrl_rx", 32'(rx_data), 32'h96);
    pulse_rd();
    check("rd_before_race", 32'(status), 32'b000);

    // rd_data in the completion cycle: completion wins.
    xfer4(8'h42, 64, 3, 16'h0, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("race_done_kept", 32'(status), 32'b010);
    check("race_rx", 32'(rx_data), 32'h42);
    pulse_ctrl(16'h0001);
    check("idle_ctrl_cs_high", 32'(cs), 32'd1);

    // Reset at cycle 20 of a transfer.
    pulse_ctrl(16'h0000);
    wdata = 16'h00FF; wr_data = 1'b1;
    tick();
    wr_data = 1'b0;
    repeat (19) tick();
    check("pre_reset_busy", 32'(status[0]), 32'd1);
    check("pre_reset_mosi", 32'(mosi), 32'd1);
    resetq = 1'b0;
    #1;
    check("mid_reset_sck", 32'(sck), 32'd0);
    check("mid_reset_mosi", 32'(mosi), 32'd0);
    check("mid_reset_cs", 32'(cs), 32'd1);
    check("mid_reset_status", 32'(status), 32'd0);
    check("mid_reset_rx", 32'(rx_data), 32'h00);
    tick();
    resetq = 1'b1;
    tick();
    pulse_ctrl(16'h0000);
    xfer4(8'h5A, 0, 0, 16'h0, cyc, mbits, pulses, mosi_or, glitch, cs_or);
    check("post_reset_busy_cycles", 32'(cyc), 32'd64);
    check("post_reset_rx", 32'(rx_data), 32'h5A);
    check("post_reset_status", 32'(status), 32'b010);

    // DIV=2 against the slave model.
    wdata2 = 16'h0000; wr_ctrl2 = 1'b1;
    tick();
    wr_ctrl2 = 1'b0;
    check("div2_cs_low", 32'(cs2), 32'd0);
    slv = 8'hC3;
    wdata2 = 16'h0011; wr_data2 = 1'b1;
    tick();
    wr_data2 = 1'b0;
    cyc = 0;
    while (status2[0] && cyc < 4000) begin
      cyc++;
      tick();
    end
    check("div2_busy_cycles", 32'(cyc), 32'd32);
    check("div2_rx", 32'(rx_data2), 32'hC3);
    check("div2_status", 32'(status2), 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
